// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: shared constants and FSM state for the ADC-to-FFT front end
package adc_fe_pkg;
  localparam int OFFSET_BASELINE = 2048;
  localparam int OFFSET_EXPERIMENTAL = 740;
  localparam int DEC_MAX = 4;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/adc_fe_fifo.sv
// adc_fe_fifo: synchronous show-ahead FIFO; the caller only asserts wr_en when
// there is room (or a read frees a slot in the same cycle).
module adc_fe_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  assign empty = r_wr_ptr == r_rd_ptr;
  assign full = r_wr_ptr == {~r_rd_ptr[AW], r_rd_ptr[AW-1:0]};
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (rd_en && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
endmodule

// File: rtl/adc_fft_frontend.sv
// adc_fft_frontend: averages one selected ADC channel, removes its offset,
// optionally saturates, tags frame boundaries and buffers for an Avalon-ST FFT sink.
module adc_fft_frontend
  import adc_fe_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int NUM_CH = 2,
  parameter int FRAME_LEN = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int OFFSET_RST = OFFSET_BASELINE + OFFSET_EXPERIMENTAL,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     adc_valid,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [2:0]               decim,
  input  logic                     sat_en,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [DATA_W-1:0]        cfg_offset,
  output logic [DATA_W-1:0]        src_data,
  output logic                     src_valid,
  input  logic                     src_ready,
  output logic                     src_sop,
  output logic                     src_eop,
  output logic [CH_W-1:0]          src_ch,
  output logic                     sat_flag,
  output logic                     ovr_flag,
  output logic                     busy
);
  localparam int ACC_W = DATA_W + 4;
  localparam int FI_W = $clog2(FRAME_LEN);
  localparam int PW = DATA_W + CH_W + 2;
  state_t r_state;
  logic [ACC_W-1:0] r_acc;
  logic [3:0] r_cnt;
  logic [CH_W-1:0] r_gch, r_a_ch, r_d_ch;
  logic [2:0] r_gdec;
  logic r_a_vld, r_d_vld, r_sat, r_ovr;
  logic [DATA_W-1:0] r_avg, r_d_data;
  logic [DATA_W-1:0] r_offset [NUM_CH];
  logic [FI_W-1:0] r_fidx;
  logic w_first, w_stb, w_last, w_ovf, w_wr, w_rd, w_full, w_empty, w_sop, w_eop;
  logic [CH_W-1:0] w_ch;
  logic [2:0] w_dec_in, w_dec;
  logic [3:0] w_len_m1;
  logic [ACC_W-1:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [DATA_W-1:0] w_clamp;
  logic [PW-1:0] w_rd_data;
  // Channel and exponent come straight from the ports on a group's first strobe.
  assign w_first = r_cnt == '0;
  assign w_ch = w_first ? ch_sel : r_gch;
  assign w_dec_in = w_first ? decim : r_gdec;
  assign w_dec = (w_dec_in > 3'(DEC_MAX)) ? 3'(DEC_MAX) : w_dec_in;
  assign w_len_m1 = 4'((5'd1 << w_dec) - 5'd1);
  assign w_sum = r_acc + ACC_W'(adc_data[w_ch*DATA_W +: DATA_W]);
  assign w_stb = r_state == RUN && adc_valid;
  assign w_last = r_cnt == w_len_m1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_gch <= '0;
      r_gdec <= '0;
      r_a_vld <= 1'b0;
      r_avg <= '0;
      r_a_ch <= '0;
    end else begin
      r_a_vld <= w_stb && w_last;
      if (r_state == IDLE) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_stb) begin
        r_acc <= w_last ? '0 : w_sum;
        r_cnt <= w_last ? '0 : r_cnt + 4'd1;
        r_gch <= w_ch;
        r_gdec <= w_dec;
        if (w_last) begin
          r_avg <= DATA_W'(w_sum >> w_dec);
          r_a_ch <= w_ch;
        end
      end
    end
  assign w_diff = {1'b0, r_avg} - {1'b0, r_offset[r_a_ch]};
  assign w_ovf = w_diff[DATA_W] ^ w_diff[DATA_W-1];
  assign w_clamp = {w_diff[DATA_W], {(DATA_W-1){~w_diff[DATA_W]}}};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_d_vld <= 1'b0;
      r_d_ch <= '0;
      r_d_data <= '0;
      r_sat <= 1'b0;
    end else begin
      r_d_vld <= r_a_vld;
      r_d_ch <= r_a_ch;
      r_d_data <= (sat_en && w_ovf) ? w_clamp : w_diff[DATA_W-1:0];
      if (r_a_vld && sat_en && w_ovf) r_sat <= 1'b1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_offset[i] <= DATA_W'(OFFSET_RST);
    end else if (cfg_we) begin
      r_offset[cfg_ch] <= cfg_offset;
    end
  // Writes are suppressed in IDLE so samples trailing a finished frame never leak out.
  assign w_rd = src_valid && src_ready;
  assign w_wr = r_d_vld && r_state == RUN && (!w_full || w_rd);
  assign w_sop = r_fidx == '0;
  assign w_eop = r_fidx == FI_W'(FRAME_LEN - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_fidx <= '0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= (r_state == IDLE) ? (en ? RUN : IDLE) : ((!en && w_wr && w_eop) ? IDLE : RUN);
      if (w_wr) r_fidx <= r_fidx + 1'b1;
      if (r_d_vld && r_state == RUN && !w_wr) r_ovr <= 1'b1;
    end
  adc_fe_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(w_wr),
    .wr_data({r_d_ch, w_sop, w_eop, r_d_data}),
    .rd_en(src_ready),
    .rd_data(w_rd_data),
    .full(w_full),
    .empty(w_empty)
  );
  assign {src_ch, src_sop, src_eop, src_data} = w_rd_data;
  assign src_valid = !w_empty;
  assign busy = r_state == RUN;
  assign sat_flag = r_sat;
  assign ovr_flag = r_ovr;
endmodule

// File: tb/tb_adc_fft_frontend.sv
// tb_adc_fft_frontend: directed and randomized checks of the ADC front end
// against a queue-based reference model.
module tb_adc_fft_frontend;
  localparam int W = 12, FL = 8, FD = 4;
  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, adc_valid = 1'b0, sat_en = 1'b1;
  logic cfg_we = 1'b0, src_ready = 1'b1, ch_sel = 1'b0, cfg_ch = 1'b0;
  logic [2*W-1:0] adc_data = '0;
  logic [2:0] decim = '0;
  logic [W-1:0] cfg_offset = '0;
  logic [W-1:0] src_data;
  logic src_valid, src_sop, src_eop, src_ch, sat_flag, ovr_flag, busy;
  always #10 clk = ~clk;
  adc_fft_frontend #(.DATA_W(W), .NUM_CH(2), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .adc_valid(adc_valid), .adc_data(adc_data),
    .ch_sel(ch_sel), .decim(decim), .sat_en(sat_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_offset(cfg_offset), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop), .src_ch(src_ch), .sat_flag(sat_flag),
    .ovr_flag(ovr_flag), .busy(busy)
  );
  typedef struct {int data; bit sop; bit eop; int ch;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int n_out, fidx, g_n, g_acc, g_ch, g_dec;
  int off[2];
  bit sat_m, ovr_m, run_m;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  // Reference: average 2^decim samples, subtract offset, clamp or wrap, tag by frame position.
  task automatic strobe();
    int v, d;
    if (g_n == 0) begin
      g_ch = int'(ch_sel);
      g_dec = int'(decim);
    end
    g_acc += int'(adc_data[g_ch*W +: W]);
    g_n++;
    if (g_n == (1 << g_dec)) begin
      d = (g_acc >> g_dec) - off[g_ch];
      if (sat_en) begin
        v = d > 2047 ? 2047 : (d < -2048 ? -2048 : d);
        if (v != d) sat_m = 1;
      end else begin
        v = d & 4095;
        if (v >= 2048) v -= 4096;
      end
      if (q.size() < FD) begin
        q.push_back('{data: v, sop: fidx == 0, eop: fidx == FL - 1, ch: g_ch});
        if (fidx == FL - 1 && !en) run_m = 0;
        fidx = (fidx + 1) % FL;
      end else ovr_m = 1;
      g_n = 0;
      g_acc = 0;
    end
  endtask
  task automatic tick();
    exp_t e;
    if (src_valid && src_ready) begin
      if (q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        n_out++;
        check("data", int'($signed(src_data)), e.data);
        check("sop", int'(src_sop), int'(e.sop));
        check("eop", int'(src_eop), int'(e.eop));
        check("ch", int'(src_ch), e.ch);
      end
    end
    if (cfg_we) off[cfg_ch] = int'(cfg_offset);
    if (adc_valid && busy && run_m) strobe();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input int v);
    int c;
    c = (g_n == 0) ? int'(ch_sel) : g_ch;
    adc_data = 24'($urandom);
    adc_data[c*W +: W] = W'(v);
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask
  task automatic drain();
    src_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    check("drain_left", q.size(), 0);
    tick();
    tick();
    check("empty_after", int'(src_valid), 0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    en = 1'b0; adc_valid = 1'b0; cfg_we = 1'b0; src_ready = 1'b1;
    decim = '0; ch_sel = 1'b0; sat_en = 1'b1;
    q.delete();
    fidx = 0; g_n = 0; g_acc = 0; n_out = 0;
    off[0] = 2788; off[1] = 2788;
    sat_m = 0; ovr_m = 0; run_m = 1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    tick();
  endtask
  task automatic cfg(input int c, input int o);
    cfg_we = 1'b1; cfg_ch = c[0]; cfg_offset = W'(o);
    tick();
    cfg_we = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    check("rst_valid", int'(src_valid), 0);
    check("rst_data", int'(src_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_sat", int'(sat_flag), 0);
    check("rst_ovr", int'(ovr_flag), 0);
    check("rst_sop", int'(src_sop) + int'(src_eop) + int'(src_ch), 0);
    do_reset();
    check("busy_run", int'(busy), 1);
    send(2788); send(4095); send(0);
    drain();
    check("sat_clamp_neg", int'(sat_flag), 1);
    do_reset();
    cfg(0, 0);
    sat_en = 1'b0;
    send(4095);
    drain();
    check("sat_unchanged", int'(sat_flag), 0);
    sat_en = 1'b1;
    send(4095);
    drain();
    check("sat_clamp_pos", int'(sat_flag), 1);
    do_reset();
    cfg(1, 0);
    decim = 3'd2; ch_sel = 1'b1;
    send(100);
    decim = 3'd0; ch_sel = 1'b0;
    send(101); send(102); send(103);
    check("lat_t0", int'(src_valid), 0);
    tick();
    check("lat_t1", int'(src_valid), 0);
    tick();
    check("lat_t2", int'(src_valid), 1);
    drain();
    check("avg_count", n_out, 1);
    do_reset();
    repeat (20) send(int'($urandom_range(0, 4095)));
    drain();
    check("frame_outs", n_out, 20);
    do_reset();
    repeat (3) send(int'($urandom_range(0, 4095)));
    en = 1'b0;
    repeat (12) send(int'($urandom_range(0, 4095)));
    drain();
    check("stop_outs", n_out, 8);
    check("stop_busy", int'(busy), 0);
    do_reset();
    src_ready = 1'b0;
    repeat (6) send(int'($urandom_range(0, 4095)));
    repeat (3) tick();
    check("ovr_flag", int'(ovr_flag), int'(ovr_m));
    check("ovr_set", int'(ovr_flag), 1);
    check("full_valid", int'(src_valid), 1);
    check("held", q.size(), 4);
    drain();
    repeat (4) send(int'($urandom_range(0, 4095)));
    drain();
    check("ovr_outs", n_out, 8);
    do_reset();
    repeat (3) send(int'($urandom_range(0, 4095)));
    src_ready = 1'b0;
    repeat (2) send(int'($urandom_range(0, 4095)));
    repeat (3) tick();
    check("pre_rst_valid", int'(src_valid), 1);
    reset_n = 1'b0;
    #1;
    check("arst_valid", int'(src_valid), 0);
    check("arst_data", int'(src_data), 0);
    check("arst_tags", int'(src_sop) + int'(src_eop) + int'(src_ch), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_flags", int'(sat_flag) + int'(ovr_flag), 0);
    do_reset();
    send(int'($urandom_range(0, 4095)));
    tick();
    tick();
    check("sop_after_rst", int'(src_sop), 1);
    drain();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (q.size() == 0 && g_n == 0 && $urandom_range(0, 15) == 0) begin
        sat_en = 1'($urandom);
        cfg(int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)));
      end
      ch_sel = 1'($urandom);
      decim = 3'($urandom_range(0, 4));
      src_ready = ($urandom_range(0, 3) != 0);
      adc_valid = (q.size() < FD) && ($urandom_range(0, 1) == 1);
      adc_data = 24'($urandom);
      tick();
      adc_valid = 1'b0;
    end
    drain();
    check("rand_sat", int'(sat_flag), int'(sat_m));
    check("rand_ovr", int'(ovr_flag), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_fft_frontend.md
ADC_FFT_FRONTEND -- requirements
Module: adc_fft_frontend

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning ADC sample width and output sample width.
REQ-002 SHALL have parameter NUM_CH, default 2, meaning the number of ADC channels presented in parallel.
REQ-003 SHALL have parameter FRAME_LEN, default 1024, meaning samples per FFT frame; it is a power of two, at least 4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries; it is a power of two.
REQ-005 SHALL have parameter OFFSET_RST, default 2788, meaning the reset value of every channel offset (2048 baseline + 740 trim).
REQ-006 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, 50 MHz domain.
- reset_n, in, 1: reset, asynchronous assert, active-low.
- en, in, 1: start/stop framing.
- adc_valid, in, 1: sample strobe; data is already synchronised to clk.
- adc_data, in, NUM_CH*DATA_W: offset-binary samples; channel k is at bits [k*DATA_W +: DATA_W].
- ch_sel, in, clog2(NUM_CH): channel routed to the FFT.
- decim, in, 3: averaging exponent; the block averages 2^decim samples per output, valid range 0..4.
- sat_en, in, 1: 1 = saturate, 0 = legacy truncation.
- cfg_we, in, 1: offset write strobe.
- cfg_ch, in, clog2(NUM_CH): channel whose offset is written.
- cfg_offset, in, DATA_W: new offset value.
- src_data, out, DATA_W: signed sample to the FFT sink.
- src_valid, out, 1: Avalon-ST valid.
- src_ready, in, 1: Avalon-ST ready.
- src_sop, out, 1: first sample of a frame.
- src_eop, out, 1: last sample of a frame.
- src_ch, out, clog2(NUM_CH): channel tag of the sample.
- sat_flag, out, 1: sticky; a clamp has occurred.
- ovr_flag, out, 1: sticky; a sample was dropped because the FIFO was full.
- busy, out, 1: asserted while the FSM is not in IDLE.

Function
REQ-007 The FSM SHALL have two states, IDLE and RUN.
- IDLE goes to RUN when en=1.
- RUN goes to IDLE when en=0 and the sample carrying eop has been written to the FIFO.
- Dropping en mid-frame SHALL therefore complete the current frame.
REQ-008 In IDLE, adc_valid SHALL be ignored and the accumulator held clear; the FIFO SHALL continue to drain.
REQ-009 In RUN, each adc_valid SHALL add the selected channel sample, zero-extended to DATA_W+4 bits, to the accumulator.
- After 2^decim strobes, avg = acc >> decim, and the accumulator restarts at zero.
- ch_sel and decim are sampled at the first strobe of each group.
REQ-010 The block SHALL compute diff = {0,avg} - offset[ch] as a signed DATA_W+1 value. The output is then:
- sat_en=1: clamp diff to [-2^(DATA_W-1), 2^(DATA_W-1)-1], and set sat_flag on any clamp.
- sat_en=0: output diff[DATA_W-1:0] unchanged.
REQ-011 Pipeline timing, where t is the clock edge at which the last strobe of a group is captured:
- edge t+1: diff/clamp registered.
- edge t+2: FIFO write.
- With the FIFO empty, src_valid SHALL be high from edge t+2 (latency 2).
REQ-012 A frame counter (0..FRAME_LEN-1) SHALL advance only on FIFO writes.
- Index 0 is tagged sop and index FRAME_LEN-1 is tagged eop.
- The counter wraps to 0.
- Tags are stored in the FIFO alongside data and src_ch.
REQ-013 When a write finds the FIFO full, the sample SHALL be discarded, ovr_flag set, and the frame counter not advanced.
- A simultaneous read and write on a full FIFO SHALL succeed.
REQ-014 Output transfer occurs when src_valid and src_ready are both 1.
- src_data, src_sop, src_eop and src_ch SHALL stay stable while src_valid=1 and src_ready=0.
- src_valid SHALL be 0 when the FIFO is empty.
REQ-015 A cfg_we write SHALL update offset[cfg_ch] on the next edge.
- Groups whose diff stage is already past that edge use the old value.
- A write concurrent with the diff stage of the same channel uses the old value.
REQ-016 sat_flag and ovr_flag SHALL clear only on reset.

Reset
REQ-017 On reset_n=0, the block SHALL asynchronously apply:
- FSM to IDLE.
- Accumulator, strobe count, frame counter and FIFO pointers to 0.
- Every offset to OFFSET_RST.
- src_valid, src_sop, src_eop, sat_flag, ovr_flag and busy to 0.
- src_data and src_ch to 0.
REQ-018 Reset asserted mid-frame SHALL discard the partial frame; after release, the first output SHALL carry sop.

Structure
REQ-019 Package adc_fe_pkg SHALL hold:
- the OFFSET_BASELINE (2048) and OFFSET_EXPERIMENTAL (740) constants;
- the FSM state enum;
- the maximum decimation exponent (4).
REQ-020 The output buffer SHALL be a sub-module, adc_fe_fifo: synchronous, show-ahead, parametrised in width and depth, with full/empty outputs.

Verification
REQ-021 DATA_W=12, offset 2788, decim=0; input 2788 -> src_data 0; input 4095 -> 1307; input 0 -> -2048 with sat_flag=1 (sat_en=1).
REQ-022 offset written to 0, input 4095: sat_en=1 -> 2047 and sat_flag=1; sat_en=0 -> 0xFFF (-1) and sat_flag unchanged.
REQ-023 decim=2, offset 0, inputs 100, 101, 102, 103 -> a single output of 101, two cycles after the fourth strobe.
REQ-024 FRAME_LEN=8, src_ready=1, 20 strobes: sop on outputs 1, 9 and 17; eop on outputs 8 and 16. Dropping en after strobe 3 -> exactly 8 outputs, then busy=0.
REQ-025 FIFO_DEPTH=4, src_ready=0, 6 strobes -> 4 entries held and ovr_flag=1. Then src_ready=1 -> 4 outputs in order; the next accepted sample has frame index 4.
REQ-026 reset_n pulsed low at frame index 5 -> all outputs read 0 immediately; after restart with en=1, the first output carries sop.
